// File: rtl/obstacle_scroller_if.sv
// Control/status bundle between the game controller (master) and the
// obstacle scroller (slave).
interface obstacle_scroller_if #(
   parameter int LINE_W  = 8,
   parameter int SPEED_W = 2,
   parameter int SCORE_W = 8
);
   logic               enable;
   logic               freeze;
   logic               clear;
   logic [SPEED_W-1:0] speed;
   logic [4:0]         density;
   logic [LINE_W-1:0]  ledLine;
   logic               step;
   logic               passed;
   logic [SCORE_W-1:0] score;

   modport master (
      output enable, freeze, clear, speed, density,
      input  ledLine, step, passed, score
   );

   modport slave (
      input  enable, freeze, clear, speed, density,
      output ledLine, step, passed, score
   );
endinterface

// File: rtl/obstacle_scroller.sv
// Obstacle generator for the dino game: spawns obstacles pseudo-randomly at
// bit LINE_W-1 and scrolls them toward the dino at bit 0, one position per
// scroll step. Step period, spawn density and minimum gap are programmable;
// obstacles leaving bit 0 are counted in a saturating score.
module obstacle_scroller #(
   parameter int         LINE_W    = 8,
   parameter int         TICK_DIV  = 16,
   parameter int         SPEED_W   = 2,
   parameter int         MIN_GAP   = 2,
   parameter logic [7:0] LFSR_TAPS = 8'hB8,
   parameter logic [7:0] LFSR_SEED = 8'h01,
   parameter int         SCORE_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   obstacle_scroller_if.slave bus
);

   localparam int CNT_W = $clog2(TICK_DIV) + 1;
   localparam int GAP_W = $clog2(MIN_GAP + 1) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       lfsr;

   logic [CNT_W-1:0] period_m1;
   logic [CNT_W-1:0] shifted;
   logic             spawn;
   logic [7:0]       lfsr_next;
   logic [GAP_W-1:0] gap_inc;

   // Step period minus one, clamped so a period of zero behaves as one cycle.
   always_comb begin
      shifted   = CNT_W'(TICK_DIV) >> bus.speed;
      period_m1 = '0;
      if (shifted != '0) begin
         period_m1 = shifted - 1'b1;
      end
   end

   // Spawn decision and next-state values used when a step is committed.
   always_comb begin
      spawn     = (state == RUN) && (gap_cnt >= GAP_W'(MIN_GAP)) &&
                  ({1'b0, lfsr[3:0]} < bus.density);
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
      gap_inc   = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
   end

   // Control FSM, step divider, line shift register, LFSR and score.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         gap_cnt     <= GAP_W'(MIN_GAP);
         lfsr        <= LFSR_SEED;
         bus.ledLine <= '0;
         bus.step    <= 1'b0;
         bus.passed  <= 1'b0;
         bus.score   <= '0;
      end else if (bus.clear) begin
         bus.ledLine <= '0;
         gap_cnt     <= GAP_W'(MIN_GAP);
         div_cnt     <= '0;
         bus.step    <= 1'b0;
         bus.passed  <= 1'b0;
      end else if (bus.freeze) begin
         bus.step    <= 1'b0;
         bus.passed  <= 1'b0;
      end else begin
         bus.step    <= 1'b0;
         bus.passed  <= 1'b0;
         case (state)
            IDLE: begin
               div_cnt <= '0;
               if (bus.enable) begin
                  state <= RUN;
               end
            end
            RUN, DRAIN: begin
               // An empty line ends a drain before any further counting.
               if (state == DRAIN && !bus.enable && bus.ledLine == '0) begin
                  state   <= IDLE;
                  div_cnt <= '0;
               end else begin
                  if (state == RUN && !bus.enable) begin
                     state <= DRAIN;
                  end else if (state == DRAIN && bus.enable) begin
                     state <= RUN;
                  end
                  if (div_cnt >= period_m1) begin
                     div_cnt     <= '0;
                     bus.step    <= 1'b1;
                     bus.passed  <= bus.ledLine[0];
                     bus.ledLine <= {spawn, bus.ledLine[LINE_W-1:1]};
                     gap_cnt     <= spawn ? '0 : gap_inc;
                     lfsr        <= lfsr_next;
                     if (bus.ledLine[0] && bus.score != '1) begin
                        bus.score <= bus.score + 1'b1;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               div_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller: a step-level reference model
// pushes the expected line/passed/score for each scroll step into a queue,
// and each test pops and compares when the DUT raises step.
module tb_obstacle_scroller;

   localparam int LW  = 8;
   localparam int TD  = 4;
   localparam int SW  = 2;
   localparam int MG  = 2;
   localparam int SCW = 3;

   typedef struct {
      logic [LW-1:0]  line;
      logic           passed;
      logic [SCW-1:0] score;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   int n_vec = 0;
   int n_bad = 0;

   exp_t sbq[$];

   logic [LW-1:0]  m_line;
   logic [7:0]     m_lfsr;
   int             m_gap;
   logic [SCW-1:0] m_score;
   logic [4:0]     m_density;

   always #5 clk = ~clk;

   obstacle_scroller_if #(.LINE_W(LW), .SPEED_W(SW), .SCORE_W(SCW)) bus ();

   obstacle_scroller #(
      .LINE_W(LW), .TICK_DIV(TD), .SPEED_W(SW), .MIN_GAP(MG),
      .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01), .SCORE_W(SCW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   function automatic void model_reset();
      m_line  = '0;
      m_lfsr  = 8'h01;
      m_gap   = MG;
      m_score = '0;
      sbq.delete();
   endfunction

   // Predicts one scroll step and queues the expected outputs.
   function automatic void model_step(input bit run);
      bit   spawn;
      bit   pass;
      exp_t e;
      spawn  = run && (m_gap >= MG) && (int'(m_lfsr[3:0]) < int'(m_density));
      pass   = m_line[0];
      m_line = {spawn, m_line[LW-1:1]};
      m_gap  = spawn ? 0 : m_gap + 1;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
      if (pass && m_score != '1) m_score = m_score + 1'b1;
      e.line   = m_line;
      e.passed = pass;
      e.score  = m_score;
      sbq.push_back(e);
   endfunction

   task automatic wait_step(input int budget, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus.step === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.freeze  = 1'b0;
      bus.clear   = 1'b0;
      bus.speed   = '0;
      bus.density = '0;
      m_density   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (bus.ledLine !== '0) begin
         n_bad++; $display("FAIL reset_line got %h want 00", bus.ledLine);
      end
      n_vec++;
      if (bus.step !== 1'b0 || bus.passed !== 1'b0) begin
         n_bad++; $display("FAIL reset_pulses got step=%b passed=%b want 0 0", bus.step, bus.passed);
      end
      n_vec++;
      if (bus.score !== '0) begin
         n_bad++; $display("FAIL reset_score got %0d want 0", bus.score);
      end
   endtask

   task automatic test_density0();
      int   cyc;
      bit   ok;
      int   nst;
      exp_t e;
      m_density   = 5'd0;
      bus.density = 5'd0;
      bus.speed   = '0;
      bus.enable  = 1'b1;
      for (int i = 0; i < 4; i++) model_step(1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_step(20, cyc, ok);
         n_vec++;
         if (!ok) begin
            n_bad++; $display("FAIL d0_timeout step %0d got none want step", i);
         end else begin
            e = sbq.pop_front();
            if (bus.ledLine !== e.line || bus.passed !== e.passed || bus.score !== e.score) begin
               n_bad++;
               $display("FAIL d0_step%0d got %h/%b/%0d want %h/%b/%0d", i, bus.ledLine,
                        bus.passed, bus.score, e.line, e.passed, e.score);
            end
            n_vec++;
            if (cyc != ((i == 0) ? TD + 1 : TD)) begin
               n_bad++; $display("FAIL d0_period%0d got %0d want %0d", i, cyc, (i == 0) ? TD + 1 : TD);
            end
         end
      end
      bus.enable = 1'b0;
      nst = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.step === 1'b1) nst++;
      end
      n_vec++;
      if (nst != 0) begin
         n_bad++; $display("FAIL d0_idle_steps got %0d want 0", nst);
      end
   endtask

   task automatic test_spawn();
      int         cyc;
      bit         ok;
      exp_t       e;
      logic [7:0] tab[4];
      tab = '{8'h80, 8'h40, 8'h20, 8'h90};
      m_density   = 5'd16;
      bus.density = 5'd16;
      bus.enable  = 1'b1;
      for (int i = 0; i < 33; i++) model_step(1'b1);
      for (int i = 0; i < 33; i++) begin
         wait_step(20, cyc, ok);
         n_vec++;
         if (!ok) begin
            n_bad++; $display("FAIL sp_timeout step %0d got none want step", i);
         end else begin
            e = sbq.pop_front();
            if (bus.ledLine !== e.line || bus.passed !== e.passed || bus.score !== e.score) begin
               n_bad++;
               $display("FAIL sp_step%0d got %h/%b/%0d want %h/%b/%0d", i, bus.ledLine,
                        bus.passed, bus.score, e.line, e.passed, e.score);
            end
            if (i < 4) begin
               n_vec++;
               if (bus.ledLine !== tab[i]) begin
                  n_bad++; $display("FAIL sp_table%0d got %h want %h", i, bus.ledLine, tab[i]);
               end
            end
            if (i == 7 || i == 8) begin
               n_vec++;
               if (bus.passed !== (i == 8) || bus.score !== ((i == 8) ? 3'd1 : 3'd0)) begin
                  n_bad++;
                  $display("FAIL sp_first_pass%0d got %b/%0d want %b/%0d", i, bus.passed,
                           bus.score, (i == 8), (i == 8) ? 1 : 0);
               end
            end
         end
      end
      n_vec++;
      if (bus.score !== 3'd7) begin
         n_bad++; $display("FAIL sp_saturate got %0d want 7", bus.score);
      end
   endtask

   task automatic test_speed();
      int   cyc;
      bit   ok;
      exp_t e;
      int   per[3];
      per = '{2, 1, 1};
      for (int s = 0; s < 3; s++) begin
         bus.speed = SW'(s + 1);
         for (int i = 0; i < 4; i++) model_step(1'b1);
         for (int i = 0; i < 4; i++) begin
            wait_step(20, cyc, ok);
            n_vec++;
            if (!ok) begin
               n_bad++; $display("FAIL spd%0d_timeout got none want step", s + 1);
            end else begin
               e = sbq.pop_front();
               if (bus.ledLine !== e.line || bus.passed !== e.passed || bus.score !== e.score) begin
                  n_bad++;
                  $display("FAIL spd%0d_step%0d got %h/%b/%0d want %h/%b/%0d", s + 1, i,
                           bus.ledLine, bus.passed, bus.score, e.line, e.passed, e.score);
               end
               n_vec++;
               if (cyc != per[s]) begin
                  n_bad++; $display("FAIL spd%0d_period got %0d want %0d", s + 1, cyc, per[s]);
               end
            end
         end
      end
      bus.speed = '0;
   endtask

   task automatic test_drain();
      int         cyc;
      bit         ok;
      int         nst;
      exp_t       e;
      logic [7:0] tab[8];
      tab = '{8'h48, 8'h24, 8'h12, 8'h09, 8'h04, 8'h02, 8'h01, 8'h00};
      do_reset();
      m_density   = 5'd16;
      bus.density = 5'd16;
      bus.enable  = 1'b1;
      for (int i = 0; i < 4; i++) model_step(1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_step(20, cyc, ok);
         if (ok) e = sbq.pop_front();
      end
      n_vec++;
      if (bus.ledLine !== 8'h90) begin
         n_bad++; $display("FAIL dr_start got %h want 90", bus.ledLine);
      end
      bus.enable = 1'b0;
      for (int i = 0; i < 8; i++) model_step(1'b0);
      for (int i = 0; i < 8; i++) begin
         wait_step(20, cyc, ok);
         n_vec++;
         if (!ok) begin
            n_bad++; $display("FAIL dr_timeout step %0d got none want step", i);
         end else begin
            e = sbq.pop_front();
            if (bus.ledLine !== e.line || bus.passed !== e.passed || bus.score !== e.score ||
                bus.ledLine !== tab[i]) begin
               n_bad++;
               $display("FAIL dr_step%0d got %h/%b/%0d want %h/%b/%0d", i, bus.ledLine,
                        bus.passed, bus.score, tab[i], e.passed, e.score);
            end
            n_vec++;
            if (cyc != TD) begin
               n_bad++; $display("FAIL dr_period%0d got %0d want %0d", i, cyc, TD);
            end
         end
      end
      nst = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.step === 1'b1) nst++;
      end
      n_vec++;
      if (nst != 0 || bus.ledLine !== '0) begin
         n_bad++; $display("FAIL dr_idle got steps=%0d line=%h want 0 00", nst, bus.ledLine);
      end
   endtask

   task automatic test_freeze();
      int   cyc;
      bit   ok;
      exp_t e;
      do_reset();
      m_density   = 5'd16;
      bus.density = 5'd16;
      bus.enable  = 1'b1;
      model_step(1'b1);
      model_step(1'b1);
      wait_step(20, cyc, ok);
      n_vec++;
      if (!ok) begin
         n_bad++; $display("FAIL fz_first got none want step");
      end else begin
         e = sbq.pop_front();
         if (bus.ledLine !== e.line || cyc != TD + 1) begin
            n_bad++; $display("FAIL fz_first got %h/%0d want %h/%0d", bus.ledLine, cyc, e.line, TD + 1);
         end
      end
      repeat (2) @(negedge clk);
      bus.freeze = 1'b1;
      repeat (10) begin
         @(negedge clk);
         n_vec++;
         if (bus.step !== 1'b0 || bus.ledLine !== 8'h80 || bus.score !== '0) begin
            n_bad++;
            $display("FAIL fz_hold got step=%b line=%h score=%0d want 0 80 0", bus.step,
                     bus.ledLine, bus.score);
         end
      end
      bus.freeze = 1'b0;
      wait_step(20, cyc, ok);
      n_vec++;
      if (!ok) begin
         n_bad++; $display("FAIL fz_resume got none want step");
      end else begin
         e = sbq.pop_front();
         if (bus.ledLine !== e.line || cyc != 2) begin
            n_bad++; $display("FAIL fz_resume got %h/%0d want %h/2", bus.ledLine, cyc, e.line);
         end
      end
   endtask

   task automatic test_clear_reset();
      int   cyc;
      bit   ok;
      exp_t e;
      for (int i = 0; i < 8; i++) model_step(1'b1);
      for (int i = 0; i < 8; i++) begin
         wait_step(20, cyc, ok);
         n_vec++;
         if (!ok) begin
            n_bad++; $display("FAIL cl_timeout step %0d got none want step", i);
         end else begin
            e = sbq.pop_front();
            if (bus.ledLine !== e.line || bus.passed !== e.passed || bus.score !== e.score) begin
               n_bad++;
               $display("FAIL cl_step%0d got %h/%b/%0d want %h/%b/%0d", i, bus.ledLine,
                        bus.passed, bus.score, e.line, e.passed, e.score);
            end
         end
      end
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      m_line = '0;
      m_gap  = MG;
      n_vec++;
      if (bus.ledLine !== '0 || bus.score !== 3'd1 || bus.step !== 1'b0) begin
         n_bad++;
         $display("FAIL cl_clear got line=%h score=%0d step=%b want 00 1 0", bus.ledLine,
                  bus.score, bus.step);
      end
      model_step(1'b1);
      wait_step(20, cyc, ok);
      n_vec++;
      if (!ok) begin
         n_bad++; $display("FAIL cl_after got none want step");
      end else begin
         e = sbq.pop_front();
         if (bus.ledLine !== e.line || bus.ledLine !== 8'h80 || cyc != TD) begin
            n_bad++; $display("FAIL cl_after got %h/%0d want 80/%0d", bus.ledLine, cyc, TD);
         end
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.ledLine !== '0 || bus.step !== 1'b0 || bus.passed !== 1'b0 || bus.score !== '0) begin
         n_bad++;
         $display("FAIL rs_mid got %h/%b/%b/%0d want 00/0/0/0", bus.ledLine, bus.step,
                  bus.passed, bus.score);
      end
      reset = 1'b0;
      model_reset();
      model_step(1'b1);
      wait_step(20, cyc, ok);
      n_vec++;
      if (!ok) begin
         n_bad++; $display("FAIL rs_first got none want step");
      end else begin
         e = sbq.pop_front();
         if (bus.ledLine !== e.line || bus.ledLine !== 8'h80 || cyc != TD + 1) begin
            n_bad++; $display("FAIL rs_first got %h/%0d want 80/%0d", bus.ledLine, cyc, TD + 1);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.freeze  = 1'b0;
      bus.clear   = 1'b0;
      bus.speed   = '0;
      bus.density = '0;
      m_density   = '0;
      model_reset();
      test_reset();
      test_density0();
      test_spawn();
      test_speed();
      test_drain();
      test_freeze();
      test_clear_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
